// File: rtl/linear_visualizer.sv
// Linear-strip visualizer: turns 12 note records into per-note LED counts
// and colours, then launches one LED-driver frame and waits for it.
module linear_visualizer #(
    parameter int N = 16,
    parameter int BPO = 24,
    parameter int LEDS = 50,
    parameter logic [N-1:0] MIN_AMP = 16'd64,
    parameter int AMP_SHIFT = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [11:0][$clog2(BPO)-1:0]        note_pos,
    input  logic [11:0][N-1:0]                  note_amp,
    input  logic [11:0]                         note_valid,
    input  logic                                notes_ready,
    input  logic                                led_done,
    output logic                                led_start,
    output logic [11:0][23:0]                   rgb,
    output logic [11:0][$clog2(LEDS)-1:0]       led_counts,
    output logic                                busy
);
    localparam int PW = $clog2(BPO);
    localparam int CW = $clog2(LEDS);
    localparam int DIVW = N + $clog2(LEDS + 1);
    localparam int DCW = $clog2(DIVW);
    localparam int TW = N + 4;
    localparam int RW = TW + 1;

    typedef enum logic [2:0] {
        IDLE, SUM, DIV, FIXUP, COLOUR, START, WAIT_DONE
    } state_t;

    state_t state, stateNxt;
    logic [11:0][PW-1:0] posL;
    logic [11:0][N-1:0] ampC;
    logic [11:0][CW-1:0] cntR;
    logic [11:0][23:0] rgbR;
    logic [TW-1:0] total, rmd, ampSum, rmdNxt;
    logic [DIVW-1:0] dvd, divSrc, dvdNxt;
    logic [DCW-1:0] divCnt;
    logic [3:0] idx, maxIdx;
    logic [RW-1:0] trial, diff;
    logic ge, divLast;
    logic [CW+3:0] qSum, rem;
    logic [10:0] hue;
    logic [N-1:0] ampSh;
    logic [8:0] bPlus;
    logic [7:0] cR, cG, cB, fr;
    logic [23:0] colour;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] b1);
        logic [16:0] p;
        p = {9'd0, c} * {8'd0, b1};
        return 8'(p >> 8);
    endfunction

    always_comb begin
        stateNxt = state;
        led_start = 1'b0;
        busy = (state != IDLE);
        unique case (state)
            IDLE:      if (notes_ready) stateNxt = SUM;
            SUM:       stateNxt = DIV;
            DIV:       if (divLast && idx == 4'd11) stateNxt = FIXUP;
            FIXUP:     stateNxt = COLOUR;
            COLOUR:    if (idx == 4'd11) stateNxt = START;
            START: begin
                led_start = 1'b1;
                stateNxt = WAIT_DONE;
            end
            WAIT_DONE: if (led_done) stateNxt = IDLE;
            default:   stateNxt = IDLE;
        endcase
    end

    // Sum, restoring divide step, and largest-amp search
    always_comb begin
        ampSum = '0;
        qSum = '0;
        maxIdx = '0;
        for (int i = 0; i < 12; i++) begin
            ampSum = ampSum + TW'(ampC[i]);
            qSum = qSum + (CW+4)'(cntR[i]);
            if (ampC[i] > ampC[maxIdx]) maxIdx = 4'(i);
        end
        rem = (CW+4)'(LEDS) - qSum;
        divSrc = (divCnt == '0) ? DIVW'(ampC[idx] * LEDS) : dvd;
        trial = {((divCnt == '0) ? '0 : rmd), divSrc[DIVW-1]};
        diff = trial - RW'(total);
        ge = (trial >= RW'(total));
        rmdNxt = ge ? diff[TW-1:0] : trial[TW-1:0];
        dvdNxt = {divSrc[DIVW-2:0], ge};
        divLast = (divCnt == DCW'(DIVW - 1));
    end

    // Hue wheel and amplitude brightness for the current note
    always_comb begin
        hue = 11'((32'(posL[idx]) * 32'd1536) / BPO);
        fr = hue[7:0];
        ampSh = ampC[idx] >> AMP_SHIFT;
        bPlus = (ampSh > N'(255)) ? 9'd256 : {1'b0, ampSh[7:0]} + 9'd1;
        cR = 8'd0;
        cG = 8'd0;
        cB = 8'd0;
        unique case (hue[10:8])
            3'd0: begin cR = 8'd255; cG = fr; end
            3'd1: begin cR = 8'd255 - fr; cG = 8'd255; end
            3'd2: begin cG = 8'd255; cB = fr; end
            3'd3: begin cG = 8'd255 - fr; cB = 8'd255; end
            3'd4: begin cR = fr; cB = 8'd255; end
            3'd5: begin cR = 8'd255; cB = 8'd255 - fr; end
            default: ;
        endcase
        colour = (ampC[idx] == '0) ? 24'd0 :
                 {scale(cR, bPlus), scale(cG, bPlus), scale(cB, bPlus)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            posL <= '0;
            ampC <= '0;
            cntR <= '0;
            rgbR <= '0;
            total <= '0;
            rmd <= '0;
            dvd <= '0;
            divCnt <= '0;
            idx <= '0;
            rgb <= '0;
            led_counts <= '0;
        end else begin
            state <= stateNxt;
            unique case (state)
                IDLE: if (notes_ready) begin
                    for (int i = 0; i < 12; i++) begin
                        posL[i] <= note_pos[i];
                        ampC[i] <= (note_valid[i] && note_amp[i] >= MIN_AMP) ?
                                   note_amp[i] : '0;
                    end
                end
                SUM: begin
                    total <= ampSum;
                    idx <= '0;
                    divCnt <= '0;
                end
                DIV: begin
                    dvd <= dvdNxt;
                    rmd <= rmdNxt;
                    if (divLast) begin
                        cntR[idx] <= (total == '0) ? '0 : dvdNxt[CW-1:0];
                        divCnt <= '0;
                        idx <= idx + 4'd1;
                    end else begin
                        divCnt <= divCnt + DCW'(1);
                    end
                end
                FIXUP: begin
                    if (total != '0) cntR[maxIdx] <= cntR[maxIdx] + rem[CW-1:0];
                    idx <= '0;
                end
                COLOUR: begin
                    rgbR[idx] <= colour;
                    idx <= idx + 4'd1;
                end
                START: begin
                    rgb <= rgbR;
                    led_counts <= cntR;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/linear_visualizer.md
Name: linear_visualizer

Overview:
Sits between the note finder and the LED driver. It converts 12 per-note records (position within the octave, amplitude, valid) into two per-note outputs for a linear strip: an LED count and a 24-bit colour. Counts are proportional to each note's share of total amplitude. Colour is a hue taken from the note position, with brightness scaled from amplitude. It launches one LED-driver frame per accepted note frame and waits for the driver to finish before accepting another.

Parameters:
N, 16, amplitude width
BPO, 24, bins per octave; positions range 0..BPO-1
LEDS, 50, LEDs on strip; counts sum to LEDS when any note contributes
MIN_AMP, 16'd64, minimum amplitude for a note to contribute
AMP_SHIFT, 6, brightness = min(255, amp >> AMP_SHIFT)

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
note_pos  in  [11:0][$clog2(BPO)-1:0]  note position within octave
note_amp  in  [11:0][N-1:0]  note amplitude, unsigned
note_valid  in  [11:0]  note slot valid
notes_ready  in  1  one-cycle pulse when note arrays are fresh
led_done  in  1  LED driver finished the frame
led_start  out  1  one-cycle pulse that launches the LED driver
rgb  out  [11:0][23:0]  per-note colour, {R[23:16],G[15:8],B[7:0]}
led_counts  out  [11:0][$clog2(LEDS)-1:0]  LEDs per note
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: the FSM enters IDLE; led_start=0, busy=0, every rgb=0, every led_counts=0, all internal registers cleared. Reset asserted mid-frame aborts the frame and emits no led_start.
- States: IDLE -> SUM -> DIV -> FIXUP -> COLOUR -> START -> WAIT_DONE -> IDLE.
- IDLE: if notes_ready=1, latch note_pos, note_amp and note_valid, then go to SUM. notes_ready in any other state is ignored (frame dropped).
- Contribution: a note contributes iff valid && amp >= MIN_AMP; a non-contributing note is treated as amp=0.
- SUM (1 cycle): total = sum of the 12 contributing amps, width N+4, no overflow possible.
- DIV: 12 notes in index order 0..11, each taking DIVW = N+$clog2(LEDS+1) cycles.
  - Each step is a restoring serial divide: q_i = floor(amp_i*LEDS / total).
  - If total=0, every q_i=0 and the divider still runs its full cycle count, so latency is fixed.
- FIXUP (1 cycle): if total!=0, add rem = LEDS - sum(q_i) to the note with the largest amp. Ties go to the lowest index. rem is always < 12.
- COLOUR: 12 cycles, one note per cycle.
  - Hue: h = pos*1536/BPO (integer), sector = h>>8, f = h[7:0].
  - Channel values by sector:
    - 0: R=255, G=f, B=0
    - 1: R=255-f, G=255, B=0
    - 2: R=0, G=255, B=f
    - 3: R=0, G=255-f, B=255
    - 4: R=f, G=0, B=255
    - 5: R=255, G=0, B=255-f
  - Brightness: b = min(255, amp>>AMP_SHIFT); each channel out = (c*(b+1))>>8.
  - A non-contributing note gets rgb=0.
- START (1 cycle): commit the internal count and colour registers to rgb and led_counts, and assert led_start.
  - Outputs change only here and at reset; they stay stable through the whole driver frame.
- WAIT_DONE: remain here until led_done=1 is sampled, then go to IDLE. led_done seen in any other state is ignored.
  - A notes_ready arriving in the same cycle as the return to IDLE is dropped; only pulses sampled while in IDLE are accepted.
- Latency: with notes_ready sampled in cycle 0, led_start is high in cycle 15+12*DIVW. With default parameters DIVW=22, so cycle 279.
- Invariant: when total!=0, sum(led_counts)=LEDS; otherwise every count is 0.

Test Plan:
- Reset -> all outputs 0, busy=0. One frame with only note 3 valid (amp=0x4000, pos=0) -> led_start pulse exactly 279 cycles after notes_ready; counts[3]=50, all other counts 0; rgb[3]=0xFF0000.
- Notes 0,1,2 valid, amp=0x1000 each -> q=16,16,16, rem=2 goes to note 0 (tie) -> counts 18,16,16.
- Notes 5 and 7 valid with amps 0x3000 and 0x1000 -> counts 38 (37+rem 1) and 12. Colour with amp=0x4000: pos 8 -> 0x00FF00, pos 12 -> 0x00FFFF.
- Brightness: pos=0, amp=0x0800 (b=32) -> rgb=0x200000. amp=50 (below MIN_AMP), valid=1 -> count 0, rgb 0.
- All notes invalid -> led_start still fires at cycle 279 with all counts and rgb 0. A second notes_ready during WAIT_DONE is ignored: no second led_start until led_done and a new notes_ready.
- Assert rst during DIV -> no led_start, outputs 0. After release, a fresh frame completes normally and holds outputs stable until led_done.
